// File: rtl/ext_data_memory_if.sv
// Line-granular external memory bus between the L1 data cache and ext_data_memory.
// master = cache side (requester), slave = memory side (responder).
interface ext_data_memory_if;
    logic [31:0]  addr_i;
    logic         cs;
    logic         we;
    logic [255:0] data_i;
    logic [255:0] data_o;
    logic         ack;
    logic         err;

    modport master (
        output addr_i, cs, we, data_i,
        input  data_o, ack, err
    );

    modport slave (
        input  addr_i, cs, we, data_i,
        output data_o, ack, err
    );
endinterface

// File: rtl/ext_data_memory.sv
// Fixed-latency 256-bit line memory answering the cache's ext_mem requests.
// Define EXT_MEM_RANGE_CHECK_EN to flag and suppress out-of-range accesses via err.
module ext_data_memory #(
    parameter int MEM_LINES = 512,
    parameter int LATENCY   = 10
) (
    input logic               clk,
    input logic               rst,
    ext_data_memory_if.slave  bus
);
    localparam int IW = $clog2(MEM_LINES);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            we_q, we_d;
    logic [255:0]    wdata_q, wdata_d;
    logic            oor_q, oor_d;
    logic [255:0]    rdata_q, rdata_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            oor_in;
    logic            mem_wr;
    logic [255:0]    mem [MEM_LINES];

`ifdef EXT_MEM_RANGE_CHECK_EN
    logic unused_lo;
    assign oor_in    = |bus.addr_i[31:IW+5];
    assign unused_lo = ^bus.addr_i[4:0];
`else
    logic unused_hi;
    assign oor_in    = 1'b0;
    assign unused_hi = ^{bus.addr_i[31:IW+5], bus.addr_i[4:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cs) begin
                    idx_d   = bus.addr_i[IW+4:5];
                    we_d    = bus.we;
                    wdata_d = bus.data_i;
                    oor_d   = oor_in;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    err_d   = oor_q;
                    if (!we_q)
                        rdata_d = oor_q ? '0 : mem[idx_q];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; reset forces IDLE so no write can land.
    assign mem_wr = (state_q == BUSY) && (cnt_q == '0) && we_q && !oor_q;

    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[idx_q] <= wdata_q;
    end

    assign bus.data_o = rdata_q;
    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
endmodule
